// File: rtl/ysyx_23060240_mem_arbiter_pkg.sv
// Shared types and encodings for the IFU/LSU memory arbiter and its LSU formatter.
package ysyx_23060240_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_RESP = 2'd3
  } state_e;

  typedef enum logic {
    OWN_IFU = 1'b0,
    OWN_LSU = 1'b1
  } owner_e;

  localparam logic [2:0] RD_LB  = 3'b000;
  localparam logic [2:0] RD_LH  = 3'b001;
  localparam logic [2:0] RD_LW  = 3'b010;
  localparam logic [2:0] RD_LBU = 3'b100;
  localparam logic [2:0] RD_LHU = 3'b101;

  localparam logic [1:0] WR_SB = 2'b00;
  localparam logic [1:0] WR_SH = 2'b01;
  localparam logic [1:0] WR_SW = 2'b10;

endpackage

// File: rtl/ysyx_23060240_lsu_fmt.sv
// Combinational LSU lane formatting: store mask/replication and load lane extraction/extension.
module ysyx_23060240_lsu_fmt
  import ysyx_23060240_mem_arbiter_pkg::*;
(
  input  logic [1:0]  st_off,
  input  logic [1:0]  wr_ctrl,
  input  logic [31:0] st_wdata,
  output logic [3:0]  st_wmask,
  output logic [31:0] st_wdata_rep,
  input  logic [1:0]  ld_off,
  input  logic [2:0]  rd_ctrl,
  input  logic [31:0] ld_word,
  output logic [31:0] ld_data
);

  logic [31:0] byte_shift;
  logic [31:0] half_shift;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
  always_comb begin
    st_wmask     = 4'b1111;
    st_wdata_rep = st_wdata;
    case (wr_ctrl)
      WR_SB: begin
        st_wmask     = 4'b0001 << st_off;
        st_wdata_rep = {4{st_wdata[7:0]}};
      end
      WR_SH: begin
        st_wmask     = 4'b0011 << {st_off[1], 1'b0};
        st_wdata_rep = {2{st_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    byte_shift = ld_word >> {ld_off, 3'b000};
    half_shift = ld_word >> {ld_off[1], 4'b0000};
    ld_byte    = byte_shift[7:0];
    ld_half    = half_shift[15:0];
    case (rd_ctrl)
      RD_LB:   ld_data = {{24{ld_byte[7]}}, ld_byte};
      RD_LH:   ld_data = {{16{ld_half[15]}}, ld_half};
      RD_LBU:  ld_data = {24'd0, ld_byte};
      RD_LHU:  ld_data = {16'd0, ld_half};
      default: ld_data = ld_word;
    endcase
  end

endmodule

// File: rtl/ysyx_23060240_mem_arbiter.sv
// Single-outstanding memory port arbiter: LSU priority with an IFU anti-starvation limit.
module ysyx_23060240_mem_arbiter
  import ysyx_23060240_mem_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ifu_req_valid,
  output logic        ifu_req_ready,
  input  logic [31:0] ifu_addr,
  output logic        ifu_rsp_valid,
  output logic [31:0] ifu_rdata,
  input  logic        lsu_req_valid,
  output logic        lsu_req_ready,
  input  logic        lsu_wen,
  input  logic [31:0] lsu_addr,
  input  logic [31:0] lsu_wdata,
  input  logic [2:0]  lsu_rd_ctrl,
  input  logic [1:0]  lsu_wr_ctrl,
  output logic        lsu_rsp_valid,
  output logic [31:0] lsu_rdata,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_addr,
  output logic        mem_wen,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rdata
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  state_e      state_q, state_d;
  owner_e      owner_q, owner_d;
  logic [31:0] addr_q, addr_d;
  logic        wen_q, wen_d;
  logic [2:0]  rd_ctrl_q, rd_ctrl_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wmask_q, wmask_d;
  logic [3:0]  starve_q, starve_d;
  logic [31:0] ifu_rdata_q, ifu_rdata_d;
  logic [31:0] lsu_rdata_q, lsu_rdata_d;

  logic [3:0]  st_wmask;
  logic [31:0] st_wdata_rep;
  logic [31:0] ld_data;
  logic        ifu_wins;

  // Stores are formatted from the live LSU inputs at accept; loads from the latched offset.
  ysyx_23060240_lsu_fmt u_fmt (
    .st_off       (lsu_addr[1:0]),
    .wr_ctrl      (lsu_wr_ctrl),
    .st_wdata     (lsu_wdata),
    .st_wmask     (st_wmask),
    .st_wdata_rep (st_wdata_rep),
    .ld_off       (addr_q[1:0]),
    .rd_ctrl      (rd_ctrl_q),
    .ld_word      (mem_rdata),
    .ld_data      (ld_data)
  );

  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    addr_d        = addr_q;
    wen_d         = wen_q;
    rd_ctrl_d     = rd_ctrl_q;
    wdata_d       = wdata_q;
    wmask_d       = wmask_q;
    starve_d      = starve_q;
    ifu_rdata_d   = ifu_rdata_q;
    lsu_rdata_d   = lsu_rdata_q;
    ifu_req_ready = 1'b0;
    lsu_req_ready = 1'b0;
    ifu_wins      = ifu_req_valid && (!lsu_req_valid || starve_q == STARVE_LIM);

    case (state_q)
      S_IDLE: begin
        if (ifu_wins) begin
          ifu_req_ready = 1'b1;
          owner_d       = OWN_IFU;
          addr_d        = ifu_addr;
          wen_d         = 1'b0;
          rd_ctrl_d     = RD_LW;
          wdata_d       = 32'd0;
          wmask_d       = 4'b0000;
          starve_d      = 4'd0;
          state_d       = S_REQ;
        end else if (lsu_req_valid) begin
          lsu_req_ready = 1'b1;
          owner_d       = OWN_LSU;
          addr_d        = lsu_addr;
          wen_d         = lsu_wen;
          rd_ctrl_d     = lsu_rd_ctrl;
          wdata_d       = lsu_wen ? st_wdata_rep : 32'd0;
          wmask_d       = lsu_wen ? st_wmask : 4'b0000;
          if (ifu_req_valid && starve_q != STARVE_LIM) starve_d = starve_q + 4'd1;
          state_d       = S_REQ;
        end
      end
      S_REQ: begin
        if (mem_req_ready) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (mem_rsp_valid) begin
          state_d = S_RESP;
          if (owner_q == OWN_IFU) ifu_rdata_d = mem_rdata;
          else                    lsu_rdata_d = wen_q ? 32'd0 : ld_data;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  // NOTE: datapath registers are reset too, because they drive outputs that must read 0 after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      owner_q     <= OWN_IFU;
      addr_q      <= 32'd0;
      wen_q       <= 1'b0;
      rd_ctrl_q   <= RD_LW;
      wdata_q     <= 32'd0;
      wmask_q     <= 4'b0000;
      starve_q    <= 4'd0;
      ifu_rdata_q <= 32'd0;
      lsu_rdata_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      addr_q      <= addr_d;
      wen_q       <= wen_d;
      rd_ctrl_q   <= rd_ctrl_d;
      wdata_q     <= wdata_d;
      wmask_q     <= wmask_d;
      starve_q    <= starve_d;
      ifu_rdata_q <= ifu_rdata_d;
      lsu_rdata_q <= lsu_rdata_d;
    end
  end

  assign mem_req_valid = (state_q == S_REQ);
  assign mem_addr      = {addr_q[31:2], 2'b00};
  assign mem_wen       = wen_q;
  assign mem_wdata     = wdata_q;
  assign mem_wmask     = wmask_q;
  assign ifu_rsp_valid = (state_q == S_RESP) && (owner_q == OWN_IFU);
  assign lsu_rsp_valid = (state_q == S_RESP) && (owner_q == OWN_LSU);
  assign ifu_rdata     = ifu_rdata_q;
  assign lsu_rdata     = lsu_rdata_q;

endmodule

// File: tb/tb_ysyx_23060240_mem_arbiter.sv
// Self-checking bench for the memory arbiter: directed table, random transactions, arbitration, reset.
module tb_ysyx_23060240_mem_arbiter;

  localparam int STARVE_MAX = 4;

  logic        clk, rst_n;
  logic        ifu_req_valid, ifu_req_ready, ifu_rsp_valid;
  logic [31:0] ifu_addr, ifu_rdata;
  logic        lsu_req_valid, lsu_req_ready, lsu_wen, lsu_rsp_valid;
  logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
  logic [2:0]  lsu_rd_ctrl;
  logic [1:0]  lsu_wr_ctrl;
  logic        mem_req_valid, mem_req_ready, mem_wen, mem_rsp_valid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wmask;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_ifu_rdata = 32'd0;
  logic [31:0] exp_lsu_rdata = 32'd0;

  ysyx_23060240_mem_arbiter #(.STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst_n(rst_n),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
    .ifu_rsp_valid(ifu_rsp_valid), .ifu_rdata(ifu_rdata),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_wen(lsu_wen),
    .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata), .lsu_rd_ctrl(lsu_rd_ctrl), .lsu_wr_ctrl(lsu_wr_ctrl),
    .lsu_rsp_valid(lsu_rsp_valid), .lsu_rdata(lsu_rdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        is_lsu;
    logic        wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  rd_ctrl;
    logic [1:0]  wr_ctrl;
    logic [31:0] mrdata;
    logic [31:0] exp_addr;
    logic [3:0]  exp_mask;
    logic [31:0] exp_wdata;
    logic [31:0] exp_rdata;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: byte counts and arithmetic on lane offsets.
  function automatic int wr_bytes(input logic [1:0] wr);
    if (wr == 2'd0) return 1;
    if (wr == 2'd1) return 2;
    return 4;
  endfunction

  function automatic logic [3:0] m_mask(input logic [31:0] a, input logic [1:0] wr);
    int nb;
    int off;
    nb  = wr_bytes(wr);
    off = (int'(a % 4) / nb) * nb;
    return 4'(((1 << nb) - 1) << off);
  endfunction

  function automatic logic [31:0] m_wdata(input logic [31:0] d, input logic [1:0] wr);
    int nb;
    longint val;
    logic [31:0] r;
    nb  = wr_bytes(wr);
    val = longint'(d) & ((64'd1 << (8 * nb)) - 1);
    r   = 32'd0;
    for (int k = 0; k < 4 / nb; k++) r = r | 32'(val << (8 * nb * k));
    return r;
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] a, input logic [2:0] rc, input logic [31:0] w);
    int nb;
    bit sgn;
    int off;
    longint lim;
    longint raw;
    case (rc)
      3'd0:    begin nb = 1; sgn = 1'b1; end
      3'd1:    begin nb = 2; sgn = 1'b1; end
      3'd4:    begin nb = 1; sgn = 1'b0; end
      3'd5:    begin nb = 2; sgn = 1'b0; end
      default: begin nb = 4; sgn = 1'b0; end
    endcase
    off = (int'(a % 4) / nb) * nb;
    lim = 64'd1 << (8 * nb);
    raw = (longint'({32'd0, w}) >> (8 * off)) % lim;
    if (sgn && raw >= lim / 2) raw = raw - lim;
    return 32'(raw);
  endfunction

  function automatic vec_t make_vec(input logic is_lsu, input logic wen, input logic [31:0] addr,
                                    input logic [31:0] wdata, input logic [2:0] rc, input logic [1:0] wr,
                                    input logic [31:0] mrdata);
    vec_t v;
    v.is_lsu    = is_lsu;
    v.wen       = is_lsu & wen;
    v.addr      = addr;
    v.wdata     = wdata;
    v.rd_ctrl   = rc;
    v.wr_ctrl   = wr;
    v.mrdata    = mrdata;
    v.exp_addr  = addr & 32'hFFFF_FFFC;
    v.exp_mask  = v.wen ? m_mask(addr, wr) : 4'b0000;
    v.exp_wdata = v.wen ? m_wdata(wdata, wr) : 32'd0;
    if (!is_lsu)    v.exp_rdata = mrdata;
    else if (v.wen) v.exp_rdata = 32'd0;
    else            v.exp_rdata = m_load(addr, rc, mrdata);
    return v;
  endfunction

  task automatic drop_requests();
    ifu_req_valid = 1'b0;
    lsu_req_valid = 1'b0;
  endtask

  // One transaction from an idle DUT, with memory stalls on request and response.
  task automatic run_txn(input vec_t v, input int rdy_dly, input int rsp_dly);
    @(negedge clk);
    if (v.is_lsu) begin
      lsu_req_valid = 1'b1;
      lsu_wen       = v.wen;
      lsu_addr      = v.addr;
      lsu_wdata     = v.wdata;
      lsu_rd_ctrl   = v.rd_ctrl;
      lsu_wr_ctrl   = v.wr_ctrl;
    end else begin
      ifu_req_valid = 1'b1;
      ifu_addr      = v.addr;
    end
    #1;
    check("accept_ready", {30'd0, ifu_req_ready, lsu_req_ready}, v.is_lsu ? 32'd1 : 32'd2);
    if (!(v.is_lsu ? lsu_req_ready : ifu_req_ready)) begin
      drop_requests();
      return;
    end
    for (int c = 0; c <= rdy_dly; c++) begin
      @(negedge clk);
      check("req_valid", {31'd0, mem_req_valid}, 32'd1);
      check("req_addr", mem_addr, v.exp_addr);
      check("req_wmask", {28'd0, mem_wmask}, {28'd0, v.exp_mask});
      check("req_wen", {31'd0, mem_wen}, {31'd0, v.wen});
      if (v.wen) check("req_wdata", mem_wdata, v.exp_wdata);
      check("req_no_ready", {30'd0, ifu_req_ready, lsu_req_ready}, 32'd0);
      mem_req_ready = (c == rdy_dly);
      mem_rsp_valid = (c < rdy_dly);
      mem_rdata     = $urandom;
    end
    for (int c = 0; c <= rsp_dly; c++) begin
      @(negedge clk);
      mem_req_ready = 1'b0;
      check("wait_ctl", {27'd0, mem_req_valid, ifu_req_ready, lsu_req_ready, ifu_rsp_valid, lsu_rsp_valid}, 32'd0);
      mem_rsp_valid = (c == rsp_dly);
      mem_rdata     = (c == rsp_dly) ? v.mrdata : $urandom;
    end
    if (v.is_lsu) exp_lsu_rdata = v.exp_rdata;
    else          exp_ifu_rdata = v.exp_rdata;
    @(negedge clk);
    mem_rsp_valid = 1'b0;
    check("resp_valid", {30'd0, ifu_rsp_valid, lsu_rsp_valid}, v.is_lsu ? 32'd1 : 32'd2);
    check("resp_ifu_rdata", ifu_rdata, exp_ifu_rdata);
    check("resp_lsu_rdata", lsu_rdata, exp_lsu_rdata);
    check("resp_no_ready", {30'd0, ifu_req_ready, lsu_req_ready}, 32'd0);
    drop_requests();
    @(negedge clk);
    check("resp_single_pulse", {30'd0, ifu_rsp_valid, lsu_rsp_valid}, 32'd0);
    check("hold_ifu_rdata", ifu_rdata, exp_ifu_rdata);
    check("hold_lsu_rdata", lsu_rdata, exp_lsu_rdata);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ctl"}, {24'd0, ifu_req_ready, ifu_rsp_valid, lsu_req_ready, lsu_rsp_valid,
                          mem_req_valid, mem_wen, 2'd0}, 32'd0);
    check({tag, "_wmask"}, {28'd0, mem_wmask}, 32'd0);
    check({tag, "_addr"}, mem_addr, 32'd0);
    check({tag, "_wdata"}, mem_wdata, 32'd0);
    check({tag, "_ifu_rdata"}, ifu_rdata, 32'd0);
    check({tag, "_lsu_rdata"}, lsu_rdata, 32'd0);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_all_zero("reset");
    exp_ifu_rdata = 32'd0;
    exp_lsu_rdata = 32'd0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  vec_t table_v[13];

  initial begin
    int ng;
    int starve;
    bit exp_i;
    bit got_i;
    vec_t v;

    rst_n = 1'b0;
    drop_requests();
    ifu_addr = 32'd0; lsu_wen = 1'b0; lsu_addr = 32'd0; lsu_wdata = 32'd0;
    lsu_rd_ctrl = 3'd0; lsu_wr_ctrl = 2'd0;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rdata = 32'd0;

    // {is_lsu, wen, addr, wdata, rd_ctrl, wr_ctrl, mrdata, exp_addr, exp_mask, exp_wdata, exp_rdata}
    table_v[0]  = '{1'b0, 1'b0, 32'h8000_0004, 32'h0, 3'd0, 2'd0, 32'h0000_0513, 32'h8000_0004, 4'b0000, 32'h0, 32'h0000_0513};
    table_v[1]  = '{1'b1, 1'b1, 32'h8000_0013, 32'h1234_56AB, 3'd0, 2'd0, 32'h0, 32'h8000_0010, 4'b1000, 32'hABAB_ABAB, 32'h0};
    table_v[2]  = '{1'b1, 1'b1, 32'h8000_0012, 32'h1234_56AB, 3'd0, 2'd1, 32'h0, 32'h8000_0010, 4'b1100, 32'h56AB_56AB, 32'h0};
    table_v[3]  = '{1'b1, 1'b1, 32'h8000_0021, 32'h0000_BEEF, 3'd0, 2'd1, 32'h0, 32'h8000_0020, 4'b0011, 32'hBEEF_BEEF, 32'h0};
    table_v[4]  = '{1'b1, 1'b1, 32'h8000_0008, 32'hDEAD_BEEF, 3'd0, 2'd2, 32'h0, 32'h8000_0008, 4'b1111, 32'hDEAD_BEEF, 32'h0};
    table_v[5]  = '{1'b1, 1'b1, 32'h8000_0031, 32'hCAFE_F00D, 3'd0, 2'd3, 32'h0, 32'h8000_0030, 4'b1111, 32'hCAFE_F00D, 32'h0};
    table_v[6]  = '{1'b1, 1'b0, 32'h8000_0041, 32'h0, 3'd0, 2'd0, 32'h1122_80FF, 32'h8000_0040, 4'b0000, 32'h0, 32'hFFFF_FF80};
    table_v[7]  = '{1'b1, 1'b0, 32'h8000_0041, 32'h0, 3'd4, 2'd0, 32'h1122_80FF, 32'h8000_0040, 4'b0000, 32'h0, 32'h0000_0080};
    table_v[8]  = '{1'b1, 1'b0, 32'h8000_0042, 32'h0, 3'd5, 2'd0, 32'h1122_80FF, 32'h8000_0040, 4'b0000, 32'h0, 32'h0000_1122};
    table_v[9]  = '{1'b1, 1'b0, 32'h8000_0040, 32'h0, 3'd1, 2'd0, 32'h1122_80FF, 32'h8000_0040, 4'b0000, 32'h0, 32'hFFFF_80FF};
    table_v[10] = '{1'b1, 1'b0, 32'h8000_0043, 32'h0, 3'd0, 2'd0, 32'h1122_80FF, 32'h8000_0040, 4'b0000, 32'h0, 32'h0000_0011};
    table_v[11] = '{1'b1, 1'b0, 32'h8000_0044, 32'h0, 3'd2, 2'd0, 32'h1122_80FF, 32'h8000_0044, 4'b0000, 32'h0, 32'h1122_80FF};
    table_v[12] = '{1'b1, 1'b0, 32'h8000_0047, 32'h0, 3'd7, 2'd0, 32'h8765_4321, 32'h8000_0044, 4'b0000, 32'h0, 32'h8765_4321};

    repeat (2) @(negedge clk);
    check_all_zero("por");
    rst_n = 1'b1;

    for (int i = 0; i < 13; i++) run_txn(table_v[i], 0, 0);

    // Long request stall then delayed response; junk rsp_valid during REQ must be ignored.
    run_txn(table_v[1], 5, 3);
    run_txn(table_v[6], 2, 1);

    for (int i = 0; i < 40; i++) begin
      v = make_vec(1'($urandom), 1'($urandom), $urandom, $urandom, 3'($urandom), 2'($urandom), $urandom);
      run_txn(v, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    end

    // Both requesters continuously valid; memory always ready and responding.
    pulse_reset();
    @(negedge clk);
    ifu_req_valid = 1'b1; ifu_addr = 32'h8000_1000;
    lsu_req_valid = 1'b1; lsu_wen = 1'b0; lsu_addr = 32'h8000_2000; lsu_rd_ctrl = 3'd2;
    mem_req_ready = 1'b1; mem_rsp_valid = 1'b1; mem_rdata = 32'h5A5A_1234;
    ng = 0;
    starve = 0;
    for (int cyc = 0; cyc < 200 && ng < 10; cyc++) begin
      #1;
      if (ifu_req_ready || lsu_req_ready) begin
        check("arb_one_ready", {31'd0, ifu_req_ready & lsu_req_ready}, 32'd0);
        exp_i  = (starve == STARVE_MAX);
        starve = exp_i ? 0 : ((starve + 1 > STARVE_MAX) ? STARVE_MAX : starve + 1);
        got_i  = ifu_req_ready;
        check($sformatf("arb_grant_%0d_is_ifu", ng), {31'd0, got_i}, {31'd0, exp_i});
        ng++;
      end
      @(negedge clk);
    end
    check("arb_grant_count", ng, 32'd10);
    drop_requests();
    repeat (5) @(negedge clk);
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0;
    check("arb_ifu_rdata", ifu_rdata, 32'h5A5A_1234);
    check("arb_lsu_rdata", lsu_rdata, 32'h5A5A_1234);
    exp_ifu_rdata = 32'h5A5A_1234;
    exp_lsu_rdata = 32'h5A5A_1234;

    // Reset while waiting for the memory response.
    @(negedge clk);
    ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0100;
    @(negedge clk);
    ifu_req_valid = 1'b0;
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    check("pre_rst_in_wait", {31'd0, mem_req_valid}, 32'd0);
    rst_n = 1'b0;
    #1;
    check_all_zero("mid_rst");
    exp_ifu_rdata = 32'd0;
    exp_lsu_rdata = 32'd0;
    @(negedge clk);
    rst_n = 1'b1;
    mem_rsp_valid = 1'b1; mem_rdata = 32'hDEAD_DEAD;
    repeat (2) begin
      @(negedge clk);
      check("late_rsp_ignored", {29'd0, ifu_rsp_valid, lsu_rsp_valid, mem_req_valid}, 32'd0);
      check("late_rsp_rdata", ifu_rdata, 32'd0);
    end
    mem_rsp_valid = 1'b0;
    run_txn(table_v[0], 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ysyx_23060240_mem_arbiter.md
# ysyx_23060240_mem_arbiter

Shares the single physical memory port between the instruction fetch path (IFU) and the load/store path (LSU). Arbitrates with LSU priority plus an IFU anti-starvation limit and keeps one transaction outstanding at a time. Also formats LSU traffic: byte/half/word write masks and data replication on stores, lane extraction and sign/zero extension on loads. Sits between the IFU/LSU and the memory-side DPI/bus adapter.

## Interface
- STARVE_MAX, 4, number of consecutive LSU grants with IFU pending after which IFU wins the next arbitration (1..15)
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- ifu_req_valid  in  1  IFU requests fetch
- ifu_req_ready  out  1  IFU request accepted this cycle
- ifu_addr  in  32  fetch address (pc)
- ifu_rsp_valid  out  1  one-cycle pulse, ifu_rdata valid
- ifu_rdata  out  32  fetched instruction
- lsu_req_valid  in  1  LSU requests access
- lsu_req_ready  out  1  LSU request accepted this cycle
- lsu_wen  in  1  1 = store, 0 = load
- lsu_addr  in  32  byte address
- lsu_wdata  in  32  store data, low-aligned
- lsu_rd_ctrl  in  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
- lsu_wr_ctrl  in  2  store type: 00 SB, 01 SH, 10 SW
- lsu_rsp_valid  out  1  one-cycle pulse, load data valid or store complete
- lsu_rdata  out  32  extended load data; 0 for stores
- mem_req_valid  out  1  request to memory
- mem_req_ready  in  1  memory accepts request
- mem_addr  out  32  word address, {addr[31:2],2'b00}
- mem_wen  out  1  write enable
- mem_wdata  out  32  lane-replicated store data
- mem_wmask  out  4  byte write mask; 0000 on reads
- mem_rsp_valid  in  1  memory read/write complete, mem_rdata valid
- mem_rdata  in  32  raw word

## Operation
- FSM states: IDLE, REQ, WAIT, RESP.
- IDLE: winner is LSU if lsu_req_valid, unless starve_cnt==STARVE_MAX and ifu_req_valid, in which case IFU. The winner's *_req_ready is driven high combinationally in IDLE only. On handshake, latch owner, address, wen, ctrl, and formatted wdata/wmask, then go to REQ.
- REQ: mem_req_valid=1 with latched fields held stable. Go to WAIT when mem_req_ready=1.
- WAIT: go to RESP when mem_rsp_valid=1. Capture the formatted result into the owner's rdata register.
- RESP: owner's *_rsp_valid=1 for exactly one cycle, then IDLE.
- mem_rsp_valid outside WAIT is ignored.
- starve_cnt: increments (saturating at STARVE_MAX) on each LSU grant while ifu_req_valid=1; clears on any IFU grant; unchanged on an LSU grant with IFU idle.
- Store format:
  - SB: wmask=0001<<addr[1:0], wdata={4{wdata[7:0]}}
  - SH: wmask=0011<<{addr[1],1'b0}, wdata={2{wdata[15:0]}}; addr[0] is ignored
  - SW: wmask=1111
  - Undefined wr_ctrl (11) behaves as SW.
- Load format: select the byte lane by addr[1:0] or the half lane by addr[1]. Sign-extend for LB/LH, zero-extend for LBU/LHU, pass the word for LW. Undefined rd_ctrl behaves as LW.
- ifu_rdata = mem_rdata unmodified.
- rdata registers hold their value until the next response for that requester.

## Timing
- Reset (async, any state, including mid-transaction): state=IDLE, starve_cnt=0, all outputs 0 (ready/valid, mem_*, rdata). The in-flight transaction is abandoned.
- Accept in cycle N → mem_req_valid from N+1. With mem_req_ready=1 at N+1 and mem_rsp_valid=1 at N+2, rsp_valid=1 at N+3. Minimum 4 cycles per access; next accept earliest at N+4.
- Both requesters valid in the same IDLE cycle: exactly one ready. The loser's ready stays 0 and its request must be held.
- ready is never high outside IDLE, even if valid.

## Structure
- Shared package holds:
  - state enum
  - rd_ctrl encodings (LB/LH/LW/LBU/LHU)
  - wr_ctrl encodings (SB/SH/SW)
  - owner encoding (OWN_IFU, OWN_LSU)
- Sub-module ysyx_23060240_lsu_fmt is purely combinational. It produces store mask/data from (addr[1:0], wr_ctrl, wdata) and load extraction from (addr[1:0], rd_ctrl, rdata). The LSU datapath reuses it.

## Test plan
- IFU alone, addr 0x8000_0004, memory returns 0x0000_0513 one cycle after accept → mem_addr 0x8000_0004, mem_wmask 0000, ifu_rsp_valid at N+3, ifu_rdata 0x0000_0513.
- SB addr 0x8000_0013, wdata 0x1234_56AB → mem_addr 0x8000_0010, wmask 1000, wdata 0xABAB_ABAB; SH addr 0x...2 → wmask 1100.
- LB addr 0x...1 on mem_rdata 0x1122_80FF → lsu_rdata 0xFFFF_FF80; LBU on the same → 0x0000_0080; LHU addr 0x...2 → 0x0000_1122.
- Both valid continuously, STARVE_MAX=4 → grant order L,L,L,L,I,L,L,L,L,I; only one ready per IDLE cycle.
- mem_req_ready held low 5 cycles, then mem_rsp_valid delayed 3 cycles → mem_* stable throughout, single rsp pulse, no second accept before RESP completes.
- rst_n low during WAIT → all outputs 0 immediately; after release, the late mem_rsp_valid is ignored and a new IFU request completes normally.
